ahb_lite_decode_mux: RTL and testbench
======================================

Name: ahb_lite_decode_mux

Overview:
Parametrised AHB-Lite interconnect slice: one master port fanned out to NUM_S slaves, placed between a master (or master-side agent) and its slaves. It performs address-phase decode into per-slave HSEL and registers the data-phase select. It muxes HREADYOUT/HRESP/HRDATA back to the master. An integrated default slave returns the two-cycle ERROR response for unmapped transfers and logs them.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_S, 4, number of decoded slaves (1..16)
HRESP_W, 2, HRESP width; ERROR encoding = 1, OKAY = 0
SLV_BASE, '0, packed NUM_S*ADDR_W vector; slice i = base of slave i
SLV_MASK, '0, packed NUM_S*ADDR_W vector; slave i hits when (HADDR & mask_i) == base_i
CNT_W, 16, decode-error counter width

Ports:
HCLK  in  1  clock, all state on posedge
HRESET  in  1  synchronous active-high reset
HADDR  in  ADDR_W  master address
HTRANS  in  2  master transfer type
HREADY  out  1  global ready to master
HRESP  out  HRESP_W  response to master
HRDATA  out  DATA_W  read data to master
HSEL_S  out  NUM_S  per-slave select, address phase
HREADY_S  out  1  HREADY broadcast to all slaves
HREADYOUT_S  in  NUM_S  per-slave ready
HRESP_S  in  NUM_S*HRESP_W  per-slave response, slice i
HRDATA_S  in  NUM_S*DATA_W  per-slave read data, slice i
dec_err_cnt  out  CNT_W  count of unmapped NONSEQ/SEQ transfers
dec_err_addr  out  ADDR_W  address of most recent unmapped transfer

Behaviour:
- Decode (combinational): hit_i = ((HADDR & mask_i) == base_i). Overlapping hits resolve to lowest index. HSEL_S = one-hot of winner; all-zero when no hit (default slave selected) or HRESET=1. HSEL is independent of HTRANS.
- HREADY_S = HREADY.
- Data-phase select dsel (NUM_S+1 entries, extra entry = default slave): loaded with the address-phase winner on each posedge where HREADY=1. Held otherwise. Reset value = default slave.
- Output mux: HREADY/HRESP/HRDATA = HREADYOUT_S[dsel]/HRESP_S[dsel]/HRDATA_S[dsel] when dsel is a real slave. Otherwise driven by the default slave. No added latency; purely combinational from dsel.
- Default slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE: outputs HREADY=1, HRESP=0, HRDATA=0.
    - On posedge with HREADY=1, no hit, HTRANS in {NONSEQ(2), SEQ(3)}: go to DS_ERR1.
    - Unmapped IDLE(0)/BUSY(1): stay in DS_IDLE (zero-wait OKAY).
  - DS_ERR1: outputs HREADY=0, HRESP=1. Unconditionally go to DS_ERR2.
  - DS_ERR2: outputs HREADY=1, HRESP=1.
    - Next state DS_ERR1 if a new unmapped NONSEQ/SEQ is accepted this cycle; otherwise DS_IDLE.
    - A mapped transfer accepted here moves dsel to that slave.
- Error log: on every entry to DS_ERR1, dec_err_cnt increments (saturates at all-ones, never wraps) and dec_err_addr captures that transfer's HADDR.
- Reset (HRESET=1 at posedge, including mid-transfer or mid-ERROR): FSM returns to DS_IDLE and dsel to default. Resulting outputs: HREADY=1, HRESP=0, HRDATA=0, dec_err_cnt=0, dec_err_addr=0. HSEL_S=0 while HRESET=1.
- Slave wait states: while HREADYOUT_S[dsel]=0, dsel holds and the new address-phase decode is not committed. The default FSM ignores HTRANS while HREADY=0.
- HRESP_W=1: ERROR is 1'b1. For HRESP_W=2 only value 1 is produced internally; slave responses pass unmodified.

Test Plan:
- Setup: NUM_S=2, base0=0x0000_0000, base1=0x1000_0000, masks 0xF000_0000.
- Reset: assert HRESET 2 cycles mid-ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, dec_err_cnt=0, dec_err_addr=0, HSEL_S=2'b00.
- NONSEQ to 0x1000_0004, slave1 HRDATA_S=0xCAFE_F00D with 2 wait states -> HSEL_S=2'b10 in address phase; HREADY low 2 cycles, then HRDATA=0xCAFE_F00D, HRESP=0.
- Back-to-back NONSEQ 0x0000_0010 then 0x1000_0010 -> dsel switches on the accepting edge; second data phase muxes slave1 with no bubble.
- NONSEQ to unmapped 0x2000_0000 -> data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1; dec_err_cnt=1, dec_err_addr=0x2000_0000.
- IDLE to 0x3000_0000 -> HREADY=1, HRESP=0, dec_err_cnt unchanged; back-to-back unmapped NONSEQs issued in DS_ERR2 -> consecutive ERR1/ERR2 pairs, count +1 each.
- CNT_W=2, five unmapped NONSEQs -> dec_err_cnt saturates at 3. Overlap test (mask0=0x0000_0000) -> HSEL_S=2'b01 for all addresses.

Source files
------------

// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite one-master-to-NUM_S-slaves decode and response mux with an
// integrated default slave that answers unmapped transfers with ERROR and logs them.
//
// state   | meaning
// DS_IDLE | default slave idle or giving zero-wait OKAY
// DS_ERR1 | first ERROR cycle (HREADY low)
// DS_ERR2 | second ERROR cycle (HREADY high, may accept a new transfer)
module ahb_lite_decode_mux #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_S   = 4,
    parameter int HRESP_W = 2,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = '0,
    parameter int CNT_W   = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    output logic                      HREADY,
    output logic [HRESP_W-1:0]        HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    output logic [NUM_S-1:0]          HSEL_S,
    output logic                      HREADY_S,
    input  logic [NUM_S-1:0]          HREADYOUT_S,
    input  logic [NUM_S*HRESP_W-1:0]  HRESP_S,
    input  logic [NUM_S*DATA_W-1:0]   HRDATA_S,
    output logic [CNT_W-1:0]          dec_err_cnt,
    output logic [ADDR_W-1:0]         dec_err_addr
);

    localparam int DSEL_W = $clog2(NUM_S + 1);
    localparam logic [DSEL_W-1:0] DSEL_DEF = DSEL_W'(NUM_S);
    localparam logic [HRESP_W-1:0] RESP_ERR = HRESP_W'(1);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t          ds_state;
    logic               ds_ready;
    logic               ds_err;
    logic               hit;
    logic [DSEL_W-1:0]  win;
    logic [DSEL_W-1:0]  dsel;
    logic               err_req;

    // Descending scan so the lowest matching index wins on overlap.
    always_comb begin
        hit = 1'b0;
        win = DSEL_DEF;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                win = DSEL_W'(i);
            end
        end
    end

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NUM_S; i++) begin
            HSEL_S[i] = ~HRESET & hit & (win == DSEL_W'(i));
        end
    end

    always_comb begin
        HREADY = ds_ready;
        HRESP  = ds_err ? RESP_ERR : '0;
        HRDATA = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (dsel == DSEL_W'(i)) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i*HRESP_W +: HRESP_W];
                HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    assign HREADY_S = HREADY;
    assign err_req  = HREADY & ~hit & (HTRANS inside {2'b10, 2'b11});

    // win already equals DSEL_DEF on a miss.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel <= DSEL_DEF;
        end else if (HREADY) begin
            dsel <= win;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state     <= DS_IDLE;
            ds_ready     <= 1'b1;
            ds_err       <= 1'b0;
            dec_err_cnt  <= '0;
            dec_err_addr <= '0;
        end else begin
            case (ds_state)
                DS_IDLE, DS_ERR2: begin
                    if (err_req) begin
                        ds_state     <= DS_ERR1;
                        ds_ready     <= 1'b0;
                        ds_err       <= 1'b1;
                        dec_err_addr <= HADDR;
                        if (dec_err_cnt != '1) begin
                            dec_err_cnt <= dec_err_cnt + 1'b1;
                        end
                    end else begin
                        ds_state <= DS_IDLE;
                        ds_ready <= 1'b1;
                        ds_err   <= 1'b0;
                    end
                end
                DS_ERR1: begin
                    ds_state <= DS_ERR2;
                    ds_ready <= 1'b1;
                    ds_err   <= 1'b1;
                end
                default: begin
                    ds_state <= DS_IDLE;
                    ds_ready <= 1'b1;
                    ds_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// Bench for ahb_lite_decode_mux: directed AHB scenarios plus random traffic
// checked against a transfer-level model of decode, data-phase routing and error logging.
module tb_ahb_lite_decode_mux;

    localparam logic [63:0] BASE    = {32'h1000_0000, 32'h0000_0000};
    localparam logic [63:0] MASK    = {32'hF000_0000, 32'hF000_0000};
    localparam logic [63:0] MASK_OV = {32'hF000_0000, 32'h0000_0000};

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [1:0]  HREADYOUT_S;
    logic [3:0]  HRESP_S;
    logic [63:0] HRDATA_S;

    logic        hready, hready_s;
    logic [1:0]  hresp, hsel;
    logic [31:0] hrdata, eaddr;
    logic [15:0] cnt;

    logic        c2_hready, c2_hready_s;
    logic [1:0]  c2_hresp, c2_hsel, c2_cnt;
    logic [31:0] c2_hrdata, c2_eaddr;

    logic        ov_hready, ov_hready_s;
    logic [1:0]  ov_hresp, ov_hsel;
    logic [31:0] ov_hrdata, ov_eaddr;
    logic [15:0] ov_cnt;

    int vectors = 0;
    int miscompares = 0;

    int          m_tgt = -1;
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    int          ov_tgt = -1;

    always #5 HCLK = ~HCLK;

    ahb_lite_decode_mux #(.ADDR_W(32), .DATA_W(32), .NUM_S(2), .HRESP_W(2),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .CNT_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .HSEL_S(hsel),
        .HREADY_S(hready_s), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .dec_err_cnt(cnt), .dec_err_addr(eaddr));

    ahb_lite_decode_mux #(.ADDR_W(32), .DATA_W(32), .NUM_S(2), .HRESP_W(2),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .CNT_W(2)) dut_c2 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(c2_hready), .HRESP(c2_hresp), .HRDATA(c2_hrdata), .HSEL_S(c2_hsel),
        .HREADY_S(c2_hready_s), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .dec_err_cnt(c2_cnt), .dec_err_addr(c2_eaddr));

    ahb_lite_decode_mux #(.ADDR_W(32), .DATA_W(32), .NUM_S(2), .HRESP_W(2),
        .SLV_BASE(BASE), .SLV_MASK(MASK_OV), .CNT_W(16)) dut_ov (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(ov_hready), .HRESP(ov_hresp), .HRDATA(ov_hrdata), .HSEL_S(ov_hsel),
        .HREADY_S(ov_hready_s), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .dec_err_cnt(ov_cnt), .dec_err_addr(ov_eaddr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map: top nibble 0 -> slave 0, 1 -> slave 1, anything else unmapped.
    function automatic int decode(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'h1) return 1;
        return -1;
    endfunction

    function automatic logic exp_ready();
        if (m_tgt >= 0) return HREADYOUT_S[m_tgt];
        return (m_phase == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [1:0] exp_resp();
        if (m_tgt >= 0) return HRESP_S[m_tgt*2 +: 2];
        return (m_phase != 0) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_tgt >= 0) return HRDATA_S[m_tgt*32 +: 32];
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_hsel();
        int d;
        d = decode(HADDR);
        if (HRESET || d < 0) return 2'b00;
        return 2'(1 << d);
    endfunction

    task automatic model_step();
        logic rdy, ov_rdy;
        int d;
        if (HRESET) begin
            m_tgt = -1; m_phase = 0; m_cnt = 0; m_addr = '0; ov_tgt = -1;
        end else begin
            rdy    = exp_ready();
            ov_rdy = (ov_tgt < 0) ? 1'b1 : HREADYOUT_S[0];
            if (rdy) begin
                d = decode(HADDR);
                m_tgt = d;
                if (d < 0 && HTRANS >= 2'd2) begin
                    m_phase = 1;
                    m_cnt++;
                    m_addr = HADDR;
                end else begin
                    m_phase = 0;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end
            if (ov_rdy) ov_tgt = 0;
        end
    endtask

    task automatic compare();
        check("hready",   {63'd0, hready},   {63'd0, exp_ready()});
        check("hready_s", {63'd0, hready_s}, {63'd0, exp_ready()});
        check("hresp",    {62'd0, hresp},    {62'd0, exp_resp()});
        check("hrdata",   {32'd0, hrdata},   {32'd0, exp_rdata()});
        check("hsel",     {62'd0, hsel},     {62'd0, exp_hsel()});
        check("cnt",      {48'd0, cnt},      64'(m_cnt > 65535 ? 65535 : m_cnt));
        check("eaddr",    {32'd0, eaddr},    {32'd0, m_addr});
        check("c2_hready", {63'd0, c2_hready}, {63'd0, exp_ready()});
        check("c2_hready_s", {63'd0, c2_hready_s}, {63'd0, exp_ready()});
        check("c2_hresp", {62'd0, c2_hresp}, {62'd0, exp_resp()});
        check("c2_hrdata", {32'd0, c2_hrdata}, {32'd0, exp_rdata()});
        check("c2_hsel",  {62'd0, c2_hsel},  {62'd0, exp_hsel()});
        check("c2_cnt",   {62'd0, c2_cnt},   64'(m_cnt > 3 ? 3 : m_cnt));
        check("c2_eaddr", {32'd0, c2_eaddr}, {32'd0, m_addr});
        check("ov_hsel",  {62'd0, ov_hsel},  HRESET ? 64'd0 : 64'd1);
        check("ov_hready", {63'd0, ov_hready}, (ov_tgt < 0) ? 64'd1 : {63'd0, HREADYOUT_S[0]});
        check("ov_hready_s", {63'd0, ov_hready_s}, (ov_tgt < 0) ? 64'd1 : {63'd0, HREADYOUT_S[0]});
        check("ov_hresp", {62'd0, ov_hresp}, (ov_tgt < 0) ? 64'd0 : {62'd0, HRESP_S[1:0]});
        check("ov_hrdata", {32'd0, ov_hrdata}, (ov_tgt < 0) ? 64'd0 : {32'd0, HRDATA_S[31:0]});
        check("ov_cnt",   {48'd0, ov_cnt},   64'd0);
        check("ov_eaddr", {32'd0, ov_eaddr}, 64'd0);
    endtask

    initial begin
        @(posedge HCLK);
        model_step();
        forever begin
            @(negedge HCLK);
            compare();
            @(posedge HCLK);
            model_step();
        end
    end

    task automatic cyc(input logic [31:0] a, input logic [1:0] t);
        @(posedge HCLK);
        #1;
        HADDR  = a;
        HTRANS = t;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET = 1'b1; HADDR = '0; HTRANS = 2'd0;
        HREADYOUT_S = 2'b11; HRESP_S = '0; HRDATA_S = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // reset asserted while the default slave is in its first ERROR cycle
        HADDR = 32'h2000_0000; HTRANS = 2'd2;
        cyc(32'h3000_0000, 2'd0);
        HRESET = 1'b1;
        @(negedge HCLK);
        check("rst_err1_hready", {63'd0, hready}, 64'd0);
        check("rst_err1_hresp",  {62'd0, hresp},  64'd1);
        check("rst_err1_cnt",    {48'd0, cnt},    64'd1);
        check("rst_hsel",        {62'd0, hsel},   64'd0);
        next_cycle();
        next_cycle();
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_hready", {63'd0, hready}, 64'd1);
        check("rst_hresp",  {62'd0, hresp},  64'd0);
        check("rst_hrdata", {32'd0, hrdata}, 64'd0);
        check("rst_cnt",    {48'd0, cnt},    64'd0);
        check("rst_eaddr",  {32'd0, eaddr},  64'd0);

        // slave 1 read with two wait states
        cyc(32'h1000_0004, 2'd2);
        @(negedge HCLK);
        check("s1_hsel", {62'd0, hsel}, 64'd2);
        cyc(32'h0000_0000, 2'd0);
        HREADYOUT_S = 2'b01;
        @(negedge HCLK);
        check("s1_wait1", {63'd0, hready}, 64'd0);
        next_cycle();
        @(negedge HCLK);
        check("s1_wait2", {63'd0, hready}, 64'd0);
        next_cycle();
        HREADYOUT_S = 2'b11;
        HRDATA_S = {32'hCAFE_F00D, 32'h0};
        @(negedge HCLK);
        check("s1_ready", {63'd0, hready}, 64'd1);
        check("s1_rdata", {32'd0, hrdata}, 64'hCAFE_F00D);
        check("s1_resp",  {62'd0, hresp},  64'd0);

        // back-to-back slave 0 then slave 1
        cyc(32'h0000_0010, 2'd2);
        cyc(32'h1000_0010, 2'd2);
        HRDATA_S = {32'h2222_0001, 32'h1111_0000};
        @(negedge HCLK);
        check("b2b_rdata0", {32'd0, hrdata}, 64'h1111_0000);
        check("b2b_hsel1",  {62'd0, hsel},   64'd2);
        cyc(32'h3000_0000, 2'd0);
        @(negedge HCLK);
        check("b2b_rdata1", {32'd0, hrdata}, 64'h2222_0001);
        check("b2b_ready1", {63'd0, hready}, 64'd1);

        // unmapped NONSEQ, then unmapped IDLE
        cyc(32'h2000_0000, 2'd2);
        cyc(32'h3000_0000, 2'd0);
        @(negedge HCLK);
        check("err1_hready", {63'd0, hready}, 64'd0);
        check("err1_hresp",  {62'd0, hresp},  64'd1);
        next_cycle();
        @(negedge HCLK);
        check("err2_hready", {63'd0, hready}, 64'd1);
        check("err2_hresp",  {62'd0, hresp},  64'd1);
        check("err_cnt1",    {48'd0, cnt},    64'd1);
        check("err_addr1",   {32'd0, eaddr},  64'h2000_0000);
        next_cycle();
        @(negedge HCLK);
        check("idle_unmap_hready", {63'd0, hready}, 64'd1);
        check("idle_unmap_hresp",  {62'd0, hresp},  64'd0);
        check("idle_unmap_cnt",    {48'd0, cnt},    64'd1);

        // back-to-back unmapped, second issued during ERR2
        cyc(32'h2000_0004, 2'd2);
        cyc(32'h2000_0008, 2'd2);
        @(negedge HCLK);
        check("bb_err1a", {63'd0, hready}, 64'd0);
        next_cycle();
        @(negedge HCLK);
        check("bb_err2a_hready", {63'd0, hready}, 64'd1);
        check("bb_err2a_hresp",  {62'd0, hresp},  64'd1);
        check("bb_cnt2",         {48'd0, cnt},    64'd2);
        check("bb_addr2",        {32'd0, eaddr},  64'h2000_0004);
        cyc(32'h3000_0000, 2'd0);
        @(negedge HCLK);
        check("bb_err1b_hready", {63'd0, hready}, 64'd0);
        check("bb_err1b_hresp",  {62'd0, hresp},  64'd1);
        check("bb_cnt3",         {48'd0, cnt},    64'd3);
        check("bb_addr3",        {32'd0, eaddr},  64'h2000_0008);
        next_cycle();
        @(negedge HCLK);
        check("bb_err2b_hresp", {62'd0, hresp}, 64'd1);
        next_cycle();

        // two more unmapped transfers: five since reset, narrow counter saturates
        for (int k = 0; k < 2; k++) begin
            cyc(32'h2000_0000, 2'd2);
            cyc(32'h3000_0000, 2'd0);
            next_cycle();
        end
        next_cycle();
        @(negedge HCLK);
        check("sat_cnt16", {48'd0, cnt},    64'd5);
        check("sat_cnt2",  {62'd0, c2_cnt}, 64'd3);
        check("ov_hsel_any", {62'd0, ov_hsel}, 64'd1);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            next_cycle();
            HRESET = ($urandom_range(0, 99) == 0);
            r = int'($urandom_range(0, 4));
            HADDR = $urandom;
            if (r < 4) HADDR[31:28] = 4'(r);
            HTRANS = 2'($urandom_range(0, 3));
            HREADYOUT_S = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            HRESP_S = 4'($urandom);
            HRDATA_S = {$urandom, $urandom};
        end
        next_cycle();
        @(negedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
